// File: rtl/connect_pkg.sv
// Shared constants and FSM encoding for the pooled-window serializer and its byte-select mux.
package connect_pkg;
   localparam int N_ELEM = 9;
   localparam int DW     = 8;
   localparam int CNT_W  = 4;
   localparam int N_WIN  = 16;
   localparam int WIN_W  = $clog2(N_WIN);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);
   localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(N_WIN - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;
endpackage

// File: rtl/connect_mux_data.sv
// Byte-select mux: returns element cnt of the latched window, zero for unreachable indices.
// Latency 0 (combinational); no flow control of its own.
module connect_mux_data
   import connect_pkg::*;
(
   input  logic [N_ELEM*DW-1:0] pool_lin,
   input  logic [CNT_W-1:0]     cnt,
   output logic [DW-1:0]        mux_data
);
   assign mux_data = (cnt <= LAST_IDX) ? pool_lin[cnt*DW +: DW] : '0;
endmodule

// File: rtl/connect_pool_serializer.sv
// Serializes one latched 3x3 pooled window into bytes, first byte the cycle after accept.
// out_ready low freezes the beat; a new window is accepted on the final-beat handshake with no bubble.
module connect_pool_serializer
   import connect_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pool_valid,
   output logic                 pool_ready,
   input  logic [N_ELEM*DW-1:0] pool_lin,
   output logic [N_ELEM*DW-1:0] pool_buf,
   output logic [CNT_W-1:0]     cnt,
   input  logic [DW-1:0]        mux_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic                 out_last,
   output logic                 out_flast,
   output logic                 frame_done
);
   state_t           state;
   logic [WIN_W-1:0] win_cnt;

   assign out_valid  = (state == ST_STREAM);
   assign out_data   = mux_data;
   assign out_last   = (state == ST_STREAM) && (cnt == LAST_IDX);
   assign out_flast  = out_last && (win_cnt == LAST_WIN);
   assign pool_ready = (state == ST_IDLE) || (out_last && out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         pool_buf   <= '0;
         cnt        <= '0;
         win_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pool_valid) begin
                  pool_buf <= pool_lin;
                  cnt      <= '0;
                  state    <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (out_ready) begin
                  if (cnt == LAST_IDX) begin
                     cnt        <= '0;
                     win_cnt    <= (win_cnt == LAST_WIN) ? '0 : win_cnt + 1'b1;
                     frame_done <= (win_cnt == LAST_WIN);
                     // Reload on the final beat keeps back-to-back windows bubble-free.
                     if (pool_valid) begin
                        pool_buf <= pool_lin;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
